multiplier_sc_mac_pipelined: RTL and testbench

- Pipelined, precision-configurable multiply-accumulate unit.
- FULL mode: one WIDTH x WIDTH multiply. HALF mode: two independent LANE_W x LANE_W multiplies. Each operand is signed or unsigned under its own control.
- An optional accumulator follows the multiplier. It is one 2*ACC_LANE_W register in FULL mode, split into two carry-isolated ACC_LANE_W lanes in HALF mode.
- Compute primitive for the soft-DSP tiles; accepts one operation per clock.

---
 rtl/multiplier_sc_mac_pipelined.sv | 159 +++++++++++++++
 tb/tb_multiplier_sc_mac_pipelined.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_sc_mac_pipelined.sv
// Pipelined multiply-accumulate with FULL (one WIDTH x WIDTH) and HALF
// (two LANE_W x LANE_W) precision modes, per-operand signedness, and an
// optional accumulator that splits into two carry-isolated lanes in HALF mode.
// Fixed latency of three clocks, one operation per clock, no stalls.
module multiplier_sc_mac_pipelined #(
    parameter int LANE_W     = 4,
    parameter int WIDTH      = 2*LANE_W+1,
    parameter int ACC_LANE_W = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          A,
    input  logic [WIDTH-1:0]          B,
    input  logic                      A_sign,
    input  logic                      B_sign,
    input  logic                      HALF,
    input  logic                      acc_en,
    input  logic                      acc_clear,
    output logic                      out_valid,
    output logic [2*ACC_LANE_W-1:0]   C,
    output logic [1:0]                ovf
);

    localparam int OW  = 2*ACC_LANE_W;   // result / accumulator width
    localparam int PW  = 2*WIDTH + 2;    // FULL product width after 1-bit extension
    localparam int LPW = 2*LANE_W + 2;   // lane product width after 1-bit extension

    // valid shift register: bit k is the valid of stage k
    logic [3:1] vld_pipe;

    // S1: registered operands and controls
    logic [WIDTH-1:0] s1_a, s1_b;
    logic             s1_as, s1_bs, s1_half, s1_en, s1_clr;

    // S2: registered extended product and controls that travel with it
    logic [OW-1:0]    s2_prod;
    logic             s2_half, s2_ps, s2_en, s2_clr;

    // S3: accumulator state plus mode tag and empty flag
    logic [OW-1:0]    acc;
    logic             mode_tag;
    logic             acc_empty;

    // Multiplier datapath between S1 and S2
    logic signed [PW-1:0]  a_fx, b_fx, p_full;
    logic signed [LPW-1:0] a_hx, b_hx, a_lx, b_lx, p_hi, p_lo;
    logic [OW-1:0]         prod_d;

    // Accumulate datapath between S2 and S3
    logic [OW:0]           sum_f;
    logic [ACC_LANE_W:0]   sum_h, sum_l;
    logic                  ov_f, ov_h, ov_l, load;
    logic [OW-1:0]         acc_sum;
    logic [1:0]            ov_d;

    // Extend operands one bit past their width so both signed and unsigned
    // values multiply exactly as signed numbers; the exact product is then
    // sign-extended, which matches the sign/zero extension of the result.
    always_comb begin
        a_fx   = $signed({{(WIDTH+2){s1_as & s1_a[WIDTH-1]}}, s1_a});
        b_fx   = $signed({{(WIDTH+2){s1_bs & s1_b[WIDTH-1]}}, s1_b});
        a_hx   = $signed({{(LANE_W+2){s1_as & s1_a[WIDTH-1]}}, s1_a[WIDTH-1 -: LANE_W]});
        b_hx   = $signed({{(LANE_W+2){s1_bs & s1_b[WIDTH-1]}}, s1_b[WIDTH-1 -: LANE_W]});
        a_lx   = $signed({{(LANE_W+2){s1_as & s1_a[LANE_W-1]}}, s1_a[LANE_W-1:0]});
        b_lx   = $signed({{(LANE_W+2){s1_bs & s1_b[LANE_W-1]}}, s1_b[LANE_W-1:0]});
        p_full = a_fx * b_fx;
        p_hi   = a_hx * b_hx;
        p_lo   = a_lx * b_lx;
        prod_d = s1_half ? {ACC_LANE_W'(p_hi), ACC_LANE_W'(p_lo)} : OW'(p_full);
    end

    // Lane-aware add with wrap detection; HALF lanes never see each other's carry
    always_comb begin
        sum_f   = {1'b0, acc} + {1'b0, s2_prod};
        sum_h   = {1'b0, acc[OW-1 -: ACC_LANE_W]} + {1'b0, s2_prod[OW-1 -: ACC_LANE_W]};
        sum_l   = {1'b0, acc[ACC_LANE_W-1:0]} + {1'b0, s2_prod[ACC_LANE_W-1:0]};
        ov_f    = s2_ps ? ((acc[OW-1] == s2_prod[OW-1]) && (sum_f[OW-1] != acc[OW-1]))
                        : sum_f[OW];
        ov_h    = s2_ps ? ((acc[OW-1] == s2_prod[OW-1]) && (sum_h[ACC_LANE_W-1] != acc[OW-1]))
                        : sum_h[ACC_LANE_W];
        ov_l    = s2_ps ? ((acc[ACC_LANE_W-1] == s2_prod[ACC_LANE_W-1]) &&
                           (sum_l[ACC_LANE_W-1] != acc[ACC_LANE_W-1]))
                        : sum_l[ACC_LANE_W];
        acc_sum = s2_half ? {sum_h[ACC_LANE_W-1:0], sum_l[ACC_LANE_W-1:0]} : sum_f[OW-1:0];
        ov_d    = s2_half ? {ov_h, ov_l} : {ov_f, 1'b0};
        // stale or mismatched accumulator contents are never added to
        load    = s2_clr | (s2_half != mode_tag) | acc_empty;
    end

    // Valid shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[2:1], in_valid};
    end

    // S1: capture inputs and controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_as   <= 1'b0;
            s1_bs   <= 1'b0;
            s1_half <= 1'b0;
            s1_en   <= 1'b0;
            s1_clr  <= 1'b0;
        end else begin
            s1_a    <= A;
            s1_b    <= B;
            s1_as   <= A_sign;
            s1_bs   <= B_sign;
            s1_half <= HALF;
            s1_en   <= acc_en;
            s1_clr  <= acc_clear;
        end
    end

    // S2: capture product and the controls that go with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_prod <= '0;
            s2_half <= 1'b0;
            s2_ps   <= 1'b0;
            s2_en   <= 1'b0;
            s2_clr  <= 1'b0;
        end else begin
            s2_prod <= prod_d;
            s2_half <= s1_half;
            s2_ps   <= s1_as | s1_bs;
            s2_en   <= s1_en;
            s2_clr  <= s1_clr;
        end
    end

    // S3: accumulator update and registered result; bubbles hold C and ovf
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mode_tag  <= 1'b0;
            acc_empty <= 1'b1;
            C         <= '0;
            ovf       <= 2'b00;
        end else if (vld_pipe[2]) begin
            if (s2_en) begin
                acc       <= load ? s2_prod : acc_sum;
                C         <= load ? s2_prod : acc_sum;
                ovf       <= load ? 2'b00 : ov_d;
                mode_tag  <= s2_half;
                acc_empty <= 1'b0;
            end else begin
                C         <= s2_prod;
                ovf       <= 2'b00;
            end
        end
    end

    assign out_valid = vld_pipe[3];

endmodule

// File: tb/tb_multiplier_sc_mac_pipelined.sv
// Scoreboard bench for multiplier_sc_mac_pipelined: each issued op pushes its
// expected C/ovf and arrival cycle; outputs are popped and compared.
module tb_multiplier_sc_mac_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, a_sign, b_sign, half, acc_en, acc_clear;
    logic [8:0]  a, b;
    logic        out_valid;
    logic [23:0] c;
    logic [1:0]  ovf;

    multiplier_sc_mac_pipelined #(.LANE_W(4), .WIDTH(9), .ACC_LANE_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
        .A_sign(a_sign), .B_sign(b_sign), .HALF(half), .acc_en(acc_en),
        .acc_clear(acc_clear), .out_valid(out_valid), .C(c), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] c;
        logic [1:0]  o;
        logic [31:0] due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [23:0] last_c = '0;
    logic [1:0]  last_o = '0;
    logic [23:0] m_acc  = '0;
    bit          m_tag  = 1'b0;
    bit          m_empty = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // interpret the low w bits of v as signed (s=1) or unsigned
    function automatic longint xv(input longint v, input int w, input bit s);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (s && m[w-1]) return m - (longint'(1) << w);
        return m;
    endfunction

    // one accumulator lane of width w: load or add, with range-based wrap check
    task automatic lane_upd(input longint accv, input longint p, input int w, input bit ps,
                            input bit ld, output longint res, output bit ov);
        longint s, lim;
        lim = longint'(1) << w;
        if (ld) begin
            res = p & (lim - 1);
            ov  = 1'b0;
        end else begin
            if (ps) begin
                s  = xv(accv, w, 1'b1) + p;
                ov = (s >= lim/2) || (s < -(lim/2));
            end else begin
                s  = accv + p;
                ov = (s >= lim);
            end
            res = s & (lim - 1);
        end
    endtask

    task automatic drive(input bit v, input logic [8:0] av, input logic [8:0] bv,
                         input bit as, input bit bs, input bit h, input bit en, input bit clr,
                         input bit use_k, input logic [23:0] kc, input logic [1:0] ko);
        longint ph, pl, rh, rl;
        bit     oh, ol, ld, ps;
        exp_t   e;
        in_valid = v; a = av; b = bv; a_sign = as; b_sign = bs;
        half = h; acc_en = en; acc_clear = clr;
        if (v) begin
            ps = as | bs;
            ld = clr || (h != m_tag) || m_empty || !en;
            if (!h) begin
                ph = xv(av, 9, as) * xv(bv, 9, bs);
                lane_upd(m_acc, ph, 24, ps, ld, rh, oh);
                e.c = rh[23:0];
                e.o = {oh, 1'b0};
            end else begin
                ph = xv(av >> 5, 4, as) * xv(bv >> 5, 4, bs);
                pl = xv(av, 4, as) * xv(bv, 4, bs);
                lane_upd(m_acc[23:12], ph, 12, ps, ld, rh, oh);
                lane_upd(m_acc[11:0],  pl, 12, ps, ld, rl, ol);
                e.c = {rh[11:0], rl[11:0]};
                e.o = {oh, ol};
            end
            if (en) begin
                m_acc   = e.c;
                m_tag   = h;
                m_empty = 1'b0;
            end
            if (use_k) begin
                e.c = kc;
                e.o = ko;
            end
            e.due = cyc + 3;
            sb.push_back(e);
        end
    endtask

    // advance one clock and check whatever the DUT presents after that edge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            void'(sb.pop_front());
            chk("missing_out", 32'd0, 32'd1);
        end
        if (out_valid) begin
            if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("C", c, e.c);
                chk("ovf", ovf, e.o);
                chk("latency", cyc, e.due);
                last_c = e.c;
                last_o = e.o;
            end
        end else begin
            chk("hold_C", c, last_c);
            chk("hold_ovf", ovf, last_o);
        end
    endtask

    task automatic op(input logic [8:0] av, input logic [8:0] bv, input bit as, input bit bs,
                      input bit h, input bit en, input bit clr,
                      input bit use_k, input logic [23:0] kc, input logic [1:0] ko);
        drive(1'b1, av, bv, as, bs, h, en, clr, use_k, kc, ko);
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 2'd0);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_C", c, 32'd0);
        chk("rst_valid", out_valid, 32'd0);
        chk("rst_ovf", ovf, 32'd0);
        sb.delete();
        m_acc = '0; m_tag = 1'b0; m_empty = 1'b1;
        last_c = '0; last_o = '0;
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; a_sign = 1'b0; b_sign = 1'b0;
        half = 1'b0; acc_en = 1'b0; acc_clear = 1'b0;
        #2;
        do_reset();
        idle();

        // product-only results in both modes
        op(9'h1FF, 9'h1FF, 1, 1, 0, 0, 0, 1, 24'h000001, 2'b00);
        op(9'h1FF, 9'h1FF, 0, 0, 0, 0, 0, 1, 24'h03FC01, 2'b00);
        idle(); idle(); idle();
        op(9'h100, 9'h1FF, 1, 1, 0, 0, 0, 1, 24'h000100, 2'b00);
        op(9'h107, 9'h0E8, 1, 1, 1, 0, 0, 1, 24'hFC8FC8, 2'b00);
        op(9'h117, 9'h0F8, 1, 1, 1, 0, 0, 1, 24'hFC8FC8, 2'b00);

        // accumulate with a bubble in the middle
        op(9'd3, 9'd5, 0, 0, 0, 1, 1, 1, 24'd15, 2'b00);
        op(9'd3, 9'd5, 0, 0, 0, 1, 0, 1, 24'd30, 2'b00);
        idle();
        op(9'h1FF, 9'd2, 1, 1, 0, 1, 0, 1, 24'd28, 2'b00);
        idle(); idle(); idle();

        // mode switch without clear reloads
        op(9'd3, 9'd5, 0, 0, 0, 1, 1, 1, 24'd15, 2'b00);
        op(9'd3, 9'd5, 0, 0, 0, 1, 0, 1, 24'd30, 2'b00);
        op(9'h021, 9'h021, 0, 0, 1, 1, 0, 1, 24'h001001, 2'b00);

        // lane wrap: 19 beats of 15*15 per lane, unsigned
        for (int i = 0; i < 19; i++) begin
            if (i == 17)      op(9'h1EF, 9'h1EF, 0, 0, 1, 1, 0, 1, 24'hFD2FD2, 2'b00);
            else if (i == 18) op(9'h1EF, 9'h1EF, 0, 0, 1, 1, 0, 1, 24'h0B30B3, 2'b11);
            else              op(9'h1EF, 9'h1EF, 0, 0, 1, 1, (i == 0), 0, 24'd0, 2'b00);
        end

        // random mix checked against the bench model
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else op(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0), 1'b0, 24'd0, 2'b00);
        end

        // reset mid-stream with ops in flight, then a non-clear op must load
        op(9'd7, 9'd7, 0, 0, 0, 1, 1, 1, 24'd49, 2'b00);
        op(9'd7, 9'd7, 0, 0, 0, 1, 0, 0, 24'd0, 2'b00);
        op(9'd7, 9'd7, 0, 0, 0, 1, 0, 0, 24'd0, 2'b00);
        drive(1'b1, 9'd7, 9'd7, 0, 0, 0, 1, 0, 1'b0, 24'd0, 2'b00);
        do_reset();
        op(9'd3, 9'd5, 0, 0, 0, 1, 0, 1, 24'd15, 2'b00);

        // drain, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) idle();
        chk("drain", sb.size(), 32'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
